// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences each instruction over shared memory
// with a ready handshake, drives datapath strobes, and traps illegal opcodes.
module multicycle_control_unit #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUBWORD_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       LuiCtrl,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] mem_size,
  output logic       mem_unsigned,
  output logic       illegal,
  output logic       retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_LUIWB  = 4'd12, S_TRAP   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J   = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000, OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LB = 6'b100000, OP_LH = 6'b100001, OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100, OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB = 6'b101000, OP_SH = 6'b101001, OP_SW  = 6'b101011;

  state_e     state_q, state_d;
  logic [1:0] size_q, size_d;
  logic       uns_q, uns_d;
  logic       store_q, store_d;
  logic       rdy;

  assign rdy          = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state        = state_q;
  assign mem_size     = size_q;
  assign mem_unsigned = uns_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      size_q  <= 2'b10;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      store_q <= store_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    uns_d       = uns_q;
    store_d     = store_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    LuiCtrl     = 1'b0;
    ALUSrcB     = '0;
    ALUOp       = '0;
    PCSource    = '0;
    illegal     = 1'b0;
    retire      = 1'b0;
    // Reset masks every combinational output, including the FETCH Mealy strobes.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = rdy;
          PCWrite = rdy;
          if (rdy) state_d = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          size_d  = 2'b10;
          uns_d   = 1'b0;
          store_d = 1'b0;
          state_d = S_TRAP;
          case (op)
            OP_LW:    state_d = S_MEMADR;
            OP_SW:    begin state_d = S_MEMADR; store_d = 1'b1; end
            OP_RTYPE: state_d = S_EXEC;
            OP_BEQ:   state_d = S_BRANCH;
            OP_ADDI:  state_d = S_ADDIEX;
            OP_J:     state_d = S_JUMP;
            OP_LUI:   state_d = S_LUIWB;
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SB, OP_SH: begin
              if (SUBWORD_EN) begin
                state_d = S_MEMADR;
                store_d = op[3];
                size_d  = op[0] ? 2'b01 : 2'b00;
                uns_d   = op[2];
              end
            end
            default:  state_d = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = store_q ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (rdy) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          retire   = rdy;
          if (rdy) state_d = S_FETCH;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          retire      = 1'b1;
          state_d     = S_FETCH;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_LUIWB: begin
          RegWrite = 1'b1;
          LuiCtrl  = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_TRAP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
          illegal  = 1'b1;
          state_d  = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
